// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte input handshake, divider config and serial/status outputs of the UART transmitter
interface uart_tx_fifo_if #(parameter int FIFO_AW = 4);
  logic [15:0]      cfg_divider;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_tx;
  logic             busy;
  logic [FIFO_AW:0] fifo_count;
  modport master (output cfg_divider, in_data, in_valid, input in_ready, ser_tx, busy, fifo_count);
  modport slave  (input cfg_divider, in_data, in_valid, output in_ready, ser_tx, busy, fifo_count);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a circular byte FIFO, back-to-back frames without idle gap
module uart_tx_fifo #(parameter int FIFO_AW = 4) (
  input logic clk,
  input logic reset,
  uart_tx_fifo_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t           state_q, state_d;
  logic [FIFO_AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]       mem_q [2**FIFO_AW];
  logic [7:0]       shreg_q, shreg_d;
  logic [15:0]      div_q, div_d, cnt_q, cnt_d, div_new;
  logic [2:0]       bit_q, bit_d;
  logic             ser_q, busy_q;
  logic             full, empty, push, pop, tick;
  assign empty   = wptr_q == rptr_q;
  assign full    = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) && (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign push    = bus.in_valid & ~full;
  assign tick    = cnt_q == 16'd0;
  assign div_new = bus.cfg_divider < 16'd2 ? 16'd2 : bus.cfg_divider;
  assign pop     = ~empty && (state_q == IDLE || (state_q == STOP && tick));
  assign bus.in_ready   = ~full;
  assign bus.ser_tx     = ser_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_count = wptr_q - rptr_q;
  // Next-state: bit timing, shifting, and popping a new frame from IDLE or the last STOP cycle
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    div_d   = div_q;
    bit_d   = bit_q;
    cnt_d   = tick ? div_q - 16'd1 : cnt_q - 16'd1;
    case (state_q)
      IDLE:  cnt_d = cnt_q;
      START: if (tick) begin
        state_d = DATA;
        bit_d   = 3'd0;
      end
      DATA:  if (tick) begin
        shreg_d = shreg_q >> 1;
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      default: if (tick) state_d = IDLE;
    endcase
    if (pop) begin
      state_d = START;
      shreg_d = mem_q[rptr_q[FIFO_AW-1:0]];
      div_d   = div_new;
      cnt_d   = div_new - 16'd1;
    end
    wptr_d = wptr_q + {{FIFO_AW{1'b0}}, push};
    rptr_d = rptr_q + {{FIFO_AW{1'b0}}, pop};
  end
  // State registers; the line is registered from the current state, so it trails the FSM by one clock
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      shreg_q <= '0;
      div_q   <= 16'd2;
      cnt_q   <= '0;
      bit_q   <= '0;
      ser_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      shreg_q <= shreg_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      ser_q   <= state_q == START ? 1'b0 : state_q == DATA ? shreg_q[0] : 1'b1;
      busy_q  <= (state_d != IDLE) || (wptr_d != rptr_d);
    end
  end
  // FIFO storage; contents need no reset because the pointers gate every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[FIFO_AW-1:0]] <= bus.in_data;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of latency, framing, back-to-back, FIFO full/drop, reset abort, divider clamp
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic reset;
  int   errs = 0;
  int   checks = 0;
  int   g, t;
  always #5 clk = ~clk;
  uart_tx_fifo_if bus ();
  uart_tx_fifo dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic push1(input logic [7:0] d);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_start();
    int n = 0;
    while (bus.ser_tx !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", int'(bus.ser_tx), 0);
  endtask
  task automatic rx_frame(input int div, input logic [7:0] exp, input int c0, output int gap);
    logic [9:0] w;
    logic [7:0] got;
    int bad;
    w   = {1'b1, exp, 1'b0};
    got = '0;
    bad = 0;
    gap = 0;
    while (c0 == 0 && bus.ser_tx !== 1'b0 && gap < 5000) begin
      @(negedge clk);
      gap++;
    end
    chk("rx_start", int'(bus.ser_tx), 0);
    for (int i = c0; i < 10 * div; i++) begin
      if (bus.ser_tx !== w[i / div]) bad++;
      if (i % div == div / 2 && i / div >= 1 && i / div <= 8) got[i / div - 1] = bus.ser_tx;
      @(negedge clk);
    end
    chk("frame_byte", int'(got), int'(exp));
    chk("frame_shape", bad, 0);
  endtask
  initial begin
    reset           = 1'b1;
    bus.cfg_divider = 16'd217;
    bus.in_data     = 8'h00;
    bus.in_valid    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_ser", int'(bus.ser_tx), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_count", int'(bus.fifo_count), 0);
    chk("rst_ready", int'(bus.in_ready), 1);
    push1(8'h41);
    chk("lat_k_ser", int'(bus.ser_tx), 1);
    chk("lat_k_count", int'(bus.fifo_count), 1);
    chk("lat_k_busy", int'(bus.busy), 1);
    @(negedge clk);
    chk("lat_k1_ser", int'(bus.ser_tx), 1);
    chk("lat_k1_count", int'(bus.fifo_count), 0);
    @(negedge clk);
    chk("lat_k2_ser", int'(bus.ser_tx), 0);
    rx_frame(217, 8'h41, 0, g);
    chk("single_busy_end", int'(bus.busy), 0);
    bus.in_data  = 8'h55;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_data = 8'hAA;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rx_frame(217, 8'h55, 0, g);
    rx_frame(217, 8'hAA, 0, g);
    chk("b2b_gap", g, 0);
    chk("b2b_idle", int'(bus.ser_tx), 1);
    bus.cfg_divider = 16'd4;
    push1(8'h00);
    wait_start();
    for (int i = 1; i <= 20; i++) begin
      bus.in_data  = 8'(i);
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("drop_count", int'(bus.fifo_count), 16);
    chk("drop_ready", int'(bus.in_ready), 0);
    repeat (20) @(negedge clk);
    for (int i = 1; i <= 16; i++) rx_frame(4, 8'(i), 0, g);
    chk("drop_empty", int'(bus.fifo_count), 0);
    chk("drop_busy", int'(bus.busy), 0);
    push1(8'h80);
    wait_start();
    for (int i = 0; i < 16; i++) begin
      bus.in_data  = 8'(8'h90 + i);
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_data = 8'hC0;
    t = 0;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("full_wait", t, 23);
    chk("full_ready_after_pop", int'(bus.in_ready), 1);
    @(negedge clk);
    chk("full_refill_count", int'(bus.fifo_count), 16);
    chk("full_refill_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    chk("full_drop_count", int'(bus.fifo_count), 16);
    bus.in_valid = 1'b0;
    rx_frame(4, 8'h90, 1, g);
    for (int i = 1; i < 16; i++) rx_frame(4, 8'(8'h90 + i), 0, g);
    rx_frame(4, 8'hC0, 0, g);
    chk("full_busy_end", int'(bus.busy), 0);
    bus.cfg_divider = 16'd10;
    bus.in_data     = 8'h3C;
    bus.in_valid    = 1'b1;
    @(negedge clk);
    bus.in_data = 8'h11;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_start();
    repeat (45) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ser", int'(bus.ser_tx), 1);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_count", int'(bus.fifo_count), 0);
    push1(8'hA5);
    rx_frame(10, 8'hA5, 0, g);
    bus.cfg_divider = 16'd0;
    push1(8'h5A);
    rx_frame(2, 8'h5A, 0, g);
    bus.cfg_divider = 16'd1;
    push1(8'hC3);
    rx_frame(2, 8'hC3, 0, g);
    bus.cfg_divider = 16'd217;
    bus.in_data     = 8'h0F;
    bus.in_valid    = 1'b1;
    @(negedge clk);
    bus.in_data = 8'hF0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_start();
    repeat (5) @(negedge clk);
    bus.cfg_divider = 16'd100;
    rx_frame(217, 8'h0F, 5, g);
    rx_frame(100, 8'hF0, 0, g);
    chk("divchg_gap", g, 0);
    chk("divchg_busy", int'(bus.busy), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
